tlb_refill_ctrl: RTL and testbench
==================================

Name: tlb_refill_ctrl

Overview:
- Write-side companion to the 32-entry TLB CAM.
- On a lookup miss, performs an Sv32 two-level page-table walk over a simple memory read port.
- Builds the 52-bit TLB entry, selects a victim slot and drives the CAM write port (we/write_addr/write_data).
- Also performs a full TLB flush (sfence.vma) by writing zero to all 32 slots.

Parameters:
TLB_WIDTH, 52, CAM entry width {VPN[51:32], PPN[31:10], rsvd[9:8], D7 A6 G5 U4 X3 W2 R1 V0}
TLB_HEIGHT, 32, number of CAM slots (5-bit slot index)
PA_WIDTH, 34, physical address width of mem_addr

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
walk_start  in  1  request refill for walk_vpn; sampled only in IDLE
walk_vpn  in  20  virtual page number that missed
satp_ppn  in  22  root page-table PPN
flush_req  in  1  request full TLB invalidate; sampled only in IDLE
tlb_valid_vec  in  32  current V bit of each CAM slot
mem_req  out  1  PTE read request
mem_addr  out  34  PTE byte address
mem_ready  in  1  request accepted when mem_req && mem_ready
mem_rvalid  in  1  read response valid
mem_rdata  in  32  PTE
tlb_we  out  1  CAM write enable
tlb_write_addr  out  5  CAM slot
tlb_write_data  out  52  CAM entry
busy  out  1  high in every state except IDLE
walk_done  out  1  one-cycle pulse, entry written
walk_fault  out  1  one-cycle pulse, page fault, nothing written

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-high (rst).
- Reset values: all outputs 0; state IDLE; replacement pointer rp = 0; flush counter = 0.
- Reset mid-walk or mid-flush returns to IDLE. A late mem_rvalid arriving in IDLE is ignored.
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, WRITE, FAULT, FLUSH.
- IDLE:
  - flush_req has priority over walk_start; a walk_start in the same cycle is dropped and the requester retries.
  - flush_req -> FLUSH.
  - walk_start -> latch vpn and satp_ppn, go to L1_REQ.
- L1_REQ:
  - mem_req=1, mem_addr = {satp_ppn,12'b0} + vpn[19:10]*4.
  - mem_addr is held stable until mem_ready is seen, then -> L1_WAIT.
- L1_WAIT: wait for mem_rvalid; the PTE is evaluated in that same cycle:
  - V=0, or R=0 with W=1 -> FAULT.
  - R|X=1 (superpage leaf): PTE.PPN[9:0]!=0 -> FAULT. Otherwise entry PPN = {PTE.PPN[21:10], vpn[9:0]}, go to WRITE.
  - Otherwise (pointer): L0 address = {PTE.PPN,12'b0} + vpn[9:0]*4, go to L0_REQ.
- L0_REQ / L0_WAIT: same handshake as level 1.
  - Leaf required: V=0, or R=0 with W=1, or R|X=0 -> FAULT.
  - Otherwise entry PPN = PTE.PPN, go to WRITE.
- Entry format:
  - tlb_write_data = {vpn, PPN, 2'b00, PTE[7:0]}.
  - A and D bits are copied; this block does no A/D update.
- Victim selection (evaluated in the WRITE cycle):
  - Lowest-index slot with tlb_valid_vec bit = 0.
  - If all 32 slots are valid, use slot rp and set rp <= rp+1 (wraps 31 -> 0).
  - rp is unchanged when an invalid slot is used.
- WRITE: tlb_we=1 and walk_done=1 for exactly one cycle -> IDLE.
- FAULT: walk_fault=1 for one cycle, tlb_we stays 0 -> IDLE.
- FLUSH:
  - tlb_we=1 every cycle, tlb_write_addr = counter, tlb_write_data = 0, counter increments.
  - After slot 31 is written: counter=0, rp=0 -> IDLE.
  - 32 cycles total; walk_done and walk_fault both stay 0.
- Latency (zero-wait memory, mem_ready=1, rvalid the cycle after accept):
  - walk_start at cycle N -> WRITE (walk_done) at cycle N+5.
  - Superpage walk -> WRITE at N+3.
- Outside their states: mem_addr and tlb_write_* are don't-care, but tlb_we and mem_req must be 0.

Test Plan:
- Two-level walk, satp_ppn=22'h00100, walk_vpn=20'h12345, tlb_valid_vec=32'h00000007:
  - mem_addr 34'h000100120; respond PTE1=32'h00080001.
  - mem_addr 34'h000200D14; respond PTE0=32'h02AF34CB.
  - Required: tlb_we pulse with addr 3, data {20'h12345,32'h02AF34CB}, walk_done one cycle, busy low the next cycle.
- Superpage, same vpn, PTE1=32'h0010000F -> single memory read; write data {20'h12345,32'h001D140F}.
- Faults:
  - Misaligned superpage PTE1=32'h0000040F -> walk_fault pulse, no tlb_we.
  - Invalid PTE0=32'h0 -> walk_fault pulse, no tlb_we.
- Replacement with tlb_valid_vec=32'hFFFFFFFF:
  - 33 consecutive walks write slots 0,1,...,31,0 (rp wraps).
  - Then one walk with valid_vec bit 9 clear writes slot 9, and rp stays at 1.
- Flush:
  - flush_req and walk_start asserted together in IDLE -> 32 consecutive writes (addr 0..31, data 0), no mem_req; busy high for 32 cycles.
  - After the flush, rp=0.
- Backpressure and reset:
  - Hold mem_ready=0 for 4 cycles -> mem_req and mem_addr stable.
  - Assert rst in L0_WAIT -> IDLE next cycle with all outputs 0; a subsequent stray mem_rvalid causes no write.

Source files
------------

// File: rtl/tlb_refill_ctrl_if.sv
// Bundle of the refill controller's request, memory-read and CAM-write signals.
// The master side is the refill controller; the slave side is its environment
// (requester, page-table memory port and TLB CAM).
interface tlb_refill_ctrl_if;
  logic        walk_start;
  logic [19:0] walk_vpn;
  logic [21:0] satp_ppn;
  logic        flush_req;
  logic [31:0] tlb_valid_vec;
  logic        mem_req;
  logic [33:0] mem_addr;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        tlb_we;
  logic [4:0]  tlb_write_addr;
  logic [51:0] tlb_write_data;
  logic        busy;
  logic        walk_done;
  logic        walk_fault;

  modport master (
    input  walk_start, walk_vpn, satp_ppn, flush_req, tlb_valid_vec,
    input  mem_ready, mem_rvalid, mem_rdata,
    output mem_req, mem_addr,
    output tlb_we, tlb_write_addr, tlb_write_data,
    output busy, walk_done, walk_fault
  );

  modport slave (
    output walk_start, walk_vpn, satp_ppn, flush_req, tlb_valid_vec,
    output mem_ready, mem_rvalid, mem_rdata,
    input  mem_req, mem_addr,
    input  tlb_we, tlb_write_addr, tlb_write_data,
    input  busy, walk_done, walk_fault
  );
endinterface

// File: rtl/tlb_refill_ctrl.sv
// TLB refill controller: Sv32 two-level page-table walk on a miss, builds the
// 52-bit CAM entry, picks a victim slot and writes it; also clears all 32
// slots on a flush request. All outputs are registered.
module tlb_refill_ctrl (
  input  logic               clk,
  input  logic               rst,
  tlb_refill_ctrl_if.master  bus
);

  localparam int TLB_WIDTH  = 52;
  localparam int TLB_HEIGHT = 32;
  localparam int PA_WIDTH   = 34;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_L1_REQ  = 3'd1,
    S_L1_WAIT = 3'd2,
    S_L0_REQ  = 3'd3,
    S_L0_WAIT = 3'd4,
    S_WRITE   = 3'd5,
    S_FAULT   = 3'd6,
    S_FLUSH   = 3'd7
  } state_t;

  // A PTE that can never be used: not valid, or write-only (reserved encoding).
  function automatic logic pte_bad(input logic [31:0] pte);
    return (!pte[0]) || (!pte[1] && pte[2]);
  endfunction

  // A PTE with R or X set terminates the walk.
  function automatic logic pte_leaf(input logic [31:0] pte);
    return pte[1] || pte[3];
  endfunction

  // Lowest-index invalid slot; bit 5 flags that one was found.
  function automatic logic [5:0] pick_free(input logic [31:0] vec);
    logic [5:0] res;
    res = 6'd0;
    for (int i = TLB_HEIGHT - 1; i >= 0; i--) begin
      if (!vec[i]) begin
        res = {1'b1, 5'(i)};
      end
    end
    return res;
  endfunction

  state_t                 state_r;
  logic [19:0]            vpn_r;
  logic [4:0]             rp_r;
  logic [4:0]             flush_cnt_r;
  logic                   mem_req_r;
  logic [PA_WIDTH-1:0]    mem_addr_r;
  logic                   tlb_we_r;
  logic [4:0]             tlb_write_addr_r;
  logic [TLB_WIDTH-1:0]   tlb_write_data_r;
  logic                   busy_r;
  logic                   walk_done_r;
  logic                   walk_fault_r;

  logic                   go_write_s;
  logic                   go_fault_s;
  logic                   go_l0_s;
  logic [21:0]            leaf_ppn_s;
  logic [5:0]             free_s;

  assign free_s = pick_free(bus.tlb_valid_vec);

  // Decode the returned PTE in the WAIT cycle into next-step decisions.
  always_comb begin
    go_write_s = 1'b0;
    go_fault_s = 1'b0;
    go_l0_s    = 1'b0;
    leaf_ppn_s = bus.mem_rdata[31:10];
    if (bus.mem_rvalid && (state_r == S_L1_WAIT)) begin
      if (pte_bad(bus.mem_rdata)) begin
        go_fault_s = 1'b1;
      end else if (pte_leaf(bus.mem_rdata)) begin
        // A 4 MiB superpage must be aligned: its low PPN bits must be zero.
        if (bus.mem_rdata[19:10] != 10'h000) begin
          go_fault_s = 1'b1;
        end else begin
          go_write_s = 1'b1;
          leaf_ppn_s = {bus.mem_rdata[31:20], vpn_r[9:0]};
        end
      end else begin
        go_l0_s = 1'b1;
      end
    end else if (bus.mem_rvalid && (state_r == S_L0_WAIT)) begin
      if (pte_bad(bus.mem_rdata) || !pte_leaf(bus.mem_rdata)) begin
        go_fault_s = 1'b1;
      end else begin
        go_write_s = 1'b1;
      end
    end else begin
      go_write_s = 1'b0;
    end
  end

  // Walk / flush sequencer; every output is a register set on state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= S_IDLE;
      vpn_r            <= 20'h00000;
      rp_r             <= 5'd0;
      flush_cnt_r      <= 5'd0;
      mem_req_r        <= 1'b0;
      mem_addr_r       <= 34'h0_0000_0000;
      tlb_we_r         <= 1'b0;
      tlb_write_addr_r <= 5'd0;
      tlb_write_data_r <= 52'h0;
      busy_r           <= 1'b0;
      walk_done_r      <= 1'b0;
      walk_fault_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          // Flush wins; a simultaneous walk request is dropped and retried.
          if (bus.flush_req) begin
            state_r          <= S_FLUSH;
            busy_r           <= 1'b1;
            flush_cnt_r      <= 5'd0;
            tlb_we_r         <= 1'b1;
            tlb_write_addr_r <= 5'd0;
            tlb_write_data_r <= 52'h0;
          end else if (bus.walk_start) begin
            state_r    <= S_L1_REQ;
            busy_r     <= 1'b1;
            vpn_r      <= bus.walk_vpn;
            mem_req_r  <= 1'b1;
            mem_addr_r <= {bus.satp_ppn, 12'h000} + {22'h000000, bus.walk_vpn[19:10], 2'b00};
          end else begin
            state_r <= S_IDLE;
          end
        end

        S_L1_REQ, S_L0_REQ: begin
          if (bus.mem_ready) begin
            mem_req_r <= 1'b0;
            state_r   <= (state_r == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
          end else begin
            state_r <= state_r;
          end
        end

        S_L1_WAIT, S_L0_WAIT: begin
          if (go_write_s) begin
            state_r          <= S_WRITE;
            tlb_we_r         <= 1'b1;
            walk_done_r      <= 1'b1;
            tlb_write_data_r <= {vpn_r, leaf_ppn_s, 2'b00, bus.mem_rdata[7:0]};
            if (free_s[5]) begin
              tlb_write_addr_r <= free_s[4:0];
            end else begin
              tlb_write_addr_r <= rp_r;
              rp_r             <= rp_r + 5'd1;
            end
          end else if (go_fault_s) begin
            state_r      <= S_FAULT;
            walk_fault_r <= 1'b1;
          end else if (go_l0_s) begin
            state_r    <= S_L0_REQ;
            mem_req_r  <= 1'b1;
            mem_addr_r <= {bus.mem_rdata[31:10], 12'h000} + {22'h000000, vpn_r[9:0], 2'b00};
          end else begin
            state_r <= state_r;
          end
        end

        S_WRITE: begin
          state_r     <= S_IDLE;
          tlb_we_r    <= 1'b0;
          walk_done_r <= 1'b0;
          busy_r      <= 1'b0;
        end

        S_FAULT: begin
          state_r      <= S_IDLE;
          walk_fault_r <= 1'b0;
          busy_r       <= 1'b0;
        end

        S_FLUSH: begin
          if (flush_cnt_r == 5'd31) begin
            state_r     <= S_IDLE;
            tlb_we_r    <= 1'b0;
            busy_r      <= 1'b0;
            flush_cnt_r <= 5'd0;
            rp_r        <= 5'd0;
          end else begin
            flush_cnt_r      <= flush_cnt_r + 5'd1;
            tlb_write_addr_r <= flush_cnt_r + 5'd1;
          end
        end

        default: begin
          state_r      <= S_IDLE;
          mem_req_r    <= 1'b0;
          tlb_we_r     <= 1'b0;
          busy_r       <= 1'b0;
          walk_done_r  <= 1'b0;
          walk_fault_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req        = mem_req_r;
  assign bus.mem_addr       = mem_addr_r;
  assign bus.tlb_we         = tlb_we_r;
  assign bus.tlb_write_addr = tlb_write_addr_r;
  assign bus.tlb_write_data = tlb_write_data_r;
  assign bus.busy           = busy_r;
  assign bus.walk_done      = walk_done_r;
  assign bus.walk_fault     = walk_fault_r;

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Self-checking bench for tlb_refill_ctrl: directed and randomized walks,
// replacement, flush, backpressure and reset, checked against a behavioural
// model of the Sv32 walk rules and slot replacement.
module tb_tlb_refill_ctrl;
  logic clk = 1'b0;
  logic rst;

  // 10-unit clock period.
  always #5 clk = ~clk;

  tlb_refill_ctrl_if bus_if();

  tlb_refill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int check_cnt = 0;
  int error_cnt = 0;
  int model_rp  = 0;

  int          cap_nwr;
  int          cap_done;
  int          cap_fault;
  int          cap_addr;
  int          cap_wcyc;
  logic [51:0] cap_data;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural Sv32 walk: addresses, number of reads, fault and entry.
  function automatic void model_walk(input logic [19:0] vpn, input logic [21:0] satp,
                                     input logic [31:0] p1, input logic [31:0] p0,
                                     output longint a1, output longint a0, output int nrd,
                                     output bit fault, output logic [51:0] data);
    longint ppn;
    a1    = longint'(satp) * 4096 + longint'(vpn / 1024) * 4;
    a0    = 0;
    nrd   = 1;
    fault = 1'b0;
    data  = '0;
    if (!p1[0] || (!p1[1] && p1[2])) begin
      fault = 1'b1;
    end else if (p1[1] || p1[3]) begin
      if (((p1 >> 10) % 1024) != 0) begin
        fault = 1'b1;
      end else begin
        ppn  = longint'(p1 >> 20) * 1024 + longint'(vpn % 1024);
        data = {vpn, ppn[21:0], 2'b00, p1[7:0]};
      end
    end else begin
      nrd = 2;
      a0  = longint'(p1 >> 10) * 4096 + longint'(vpn % 1024) * 4;
      if (!p0[0] || (!p0[1] && p0[2]) || !(p0[1] || p0[3])) begin
        fault = 1'b1;
      end else begin
        data = {vpn, p0[31:10], 2'b00, p0[7:0]};
      end
    end
  endfunction

  function automatic int model_free_slot(input logic [31:0] vvec);
    for (int i = 0; i < 32; i++) begin
      if (!vvec[i]) return i;
    end
    return -1;
  endfunction

  // kind 0: pointer, 1: aligned leaf, otherwise unconstrained.
  function automatic logic [31:0] rand_pte(input int kind);
    logic [31:0] p;
    p = $urandom();
    if (kind == 0) begin
      p[3:0] = 4'b0001;
    end else if (kind == 1) begin
      p[19:10] = 10'h000;
      p[1:0]   = 2'b11;
    end
    return p;
  endfunction

  task automatic run_walk(input logic [19:0] vpn, input logic [21:0] satp,
                          input logic [31:0] p1, input logic [31:0] p0,
                          input logic [31:0] vvec, input int stall);
    longint a1, a0;
    int nrd, exp_slot, v, rd_idx, stall_left, cyc;
    bit fault, resp_pending, prev_pulse;
    logic [51:0] data;
    logic [31:0] resp;
    model_walk(vpn, satp, p1, p0, a1, a0, nrd, fault, data);
    exp_slot = 0;
    if (!fault) begin
      v = model_free_slot(vvec);
      if (v < 0) begin
        exp_slot = model_rp;
        model_rp = (model_rp + 1) % 32;
      end else begin
        exp_slot = v;
      end
    end
    cap_nwr = 0; cap_done = 0; cap_fault = 0; cap_addr = 0; cap_wcyc = -1; cap_data = '0;
    rd_idx = 0; stall_left = stall; resp_pending = 1'b0; resp = 32'h0; prev_pulse = 1'b0;
    @(negedge clk);
    bus_if.walk_vpn      = vpn;
    bus_if.satp_ppn      = satp;
    bus_if.tlb_valid_vec = vvec;
    bus_if.walk_start    = 1'b1;
    @(negedge clk);
    bus_if.walk_start = 1'b0;
    cyc = 0;
    while (cyc < 200) begin
      if (prev_pulse) check_eq("busy_after_pulse", bus_if.busy, 1'b0);
      if (!bus_if.busy) break;
      bus_if.mem_rvalid = resp_pending;
      bus_if.mem_rdata  = resp;
      resp_pending      = 1'b0;
      bus_if.mem_ready  = 1'b0;
      if (bus_if.mem_req) begin
        check_eq((rd_idx == 0) ? "l1_addr" : "l0_addr", bus_if.mem_addr, (rd_idx == 0) ? a1 : a0);
        if (stall_left > 0) begin
          stall_left--;
        end else begin
          bus_if.mem_ready = 1'b1;
          resp             = (rd_idx == 0) ? p1 : p0;
          resp_pending     = 1'b1;
          rd_idx++;
        end
      end
      if (bus_if.tlb_we) begin
        cap_nwr++;
        cap_addr = bus_if.tlb_write_addr;
        cap_data = bus_if.tlb_write_data;
        cap_wcyc = cyc;
      end
      cap_done  += bus_if.walk_done;
      cap_fault += bus_if.walk_fault;
      prev_pulse = bus_if.walk_done || bus_if.walk_fault;
      cyc++;
      @(negedge clk);
    end
    bus_if.mem_ready  = 1'b0;
    bus_if.mem_rvalid = 1'b0;
    check_eq("walk_timeout", (cyc < 200), 1'b1);
    check_eq("n_reads", rd_idx, nrd);
    check_eq("n_writes", cap_nwr, fault ? 0 : 1);
    check_eq("walk_done", cap_done, fault ? 0 : 1);
    check_eq("walk_fault", cap_fault, fault ? 1 : 0);
    if (!fault) begin
      check_eq("wr_slot", cap_addr, exp_slot);
      check_eq("wr_data", cap_data, data);
      check_eq("latency", cap_wcyc, ((nrd == 2) ? 4 : 2) + stall);
    end
  endtask

  task automatic run_flush();
    int nwr, busy_cyc, cyc;
    @(negedge clk);
    bus_if.walk_vpn   = 20'h12345;
    bus_if.satp_ppn   = 22'h00100;
    bus_if.flush_req  = 1'b1;
    bus_if.walk_start = 1'b1;
    @(negedge clk);
    bus_if.flush_req  = 1'b0;
    bus_if.walk_start = 1'b0;
    nwr = 0; busy_cyc = 0; cyc = 0;
    while (cyc < 100) begin
      if (!bus_if.busy) break;
      busy_cyc++;
      check_eq("flush_we", bus_if.tlb_we, 1'b1);
      check_eq("flush_addr", bus_if.tlb_write_addr, nwr);
      check_eq("flush_data", bus_if.tlb_write_data, 52'h0);
      check_eq("flush_memreq", bus_if.mem_req, 1'b0);
      check_eq("flush_pulse", {bus_if.walk_done, bus_if.walk_fault}, 2'b00);
      if (bus_if.tlb_we) nwr++;
      cyc++;
      @(negedge clk);
    end
    check_eq("flush_writes", nwr, 32);
    check_eq("flush_busy", busy_cyc, 32);
    model_rp = 0;
  endtask

  // Bound on total run time.
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] vv;
    bus_if.walk_start    = 1'b0;
    bus_if.walk_vpn      = 20'h0;
    bus_if.satp_ppn      = 22'h0;
    bus_if.flush_req     = 1'b0;
    bus_if.tlb_valid_vec = 32'h0;
    bus_if.mem_ready     = 1'b0;
    bus_if.mem_rvalid    = 1'b0;
    bus_if.mem_rdata     = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", bus_if.busy, 1'b0);
    check_eq("rst_mem_req", bus_if.mem_req, 1'b0);
    check_eq("rst_mem_addr", bus_if.mem_addr, 34'h0);
    check_eq("rst_we", bus_if.tlb_we, 1'b0);
    check_eq("rst_waddr", bus_if.tlb_write_addr, 5'd0);
    check_eq("rst_wdata", bus_if.tlb_write_data, 52'h0);
    check_eq("rst_done", bus_if.walk_done, 1'b0);
    check_eq("rst_fault", bus_if.walk_fault, 1'b0);
    rst = 1'b0;

    // Directed walks from the reference scenarios.
    run_walk(20'h12345, 22'h00100, 32'h00080001, 32'h02AF34CB, 32'h00000007, 0);
    check_eq("tp_two_level_slot", cap_addr, 3);
    check_eq("tp_two_level_data", cap_data, 52'h12345_02AF34CB);
    run_walk(20'h12345, 22'h00100, 32'h0010000F, 32'h00000000, 32'h00000007, 0);
    check_eq("tp_superpage_data", cap_data, 52'h12345_001D140F);
    run_walk(20'h12345, 22'h00100, 32'h0000040F, 32'h00000000, 32'h00000007, 0);
    check_eq("tp_misaligned_fault", cap_fault, 1);
    run_walk(20'h12345, 22'h00100, 32'h00080001, 32'h00000000, 32'h00000007, 0);
    check_eq("tp_invalid_l0_fault", cap_fault, 1);

    // Backpressure on the first read.
    run_walk(20'hABCDE, 22'h2F0F0, 32'h00080001, 32'h02AF34CB, 32'h00000000, 4);

    // Round-robin replacement with every slot valid.
    for (int i = 0; i < 33; i++) begin
      run_walk(20'($urandom()), 22'($urandom()), rand_pte(1), 32'h0, 32'hFFFFFFFF, 0);
      check_eq("rr_slot", cap_addr, i % 32);
    end
    run_walk(20'h00042, 22'h00011, rand_pte(1), 32'h0, 32'hFFFFFDFF, 0);
    check_eq("free_slot9", cap_addr, 9);
    run_walk(20'h00043, 22'h00011, rand_pte(1), 32'h0, 32'hFFFFFFFF, 0);
    check_eq("rp_kept_at_1", cap_addr, 1);

    // Flush with a simultaneous walk request; replacement restarts at 0.
    run_flush();
    run_walk(20'h00044, 22'h00011, rand_pte(1), 32'h0, 32'hFFFFFFFF, 0);
    check_eq("rp_after_flush", cap_addr, 0);

    // Randomized walks.
    for (int i = 0; i < 60; i++) begin
      vv = $urandom();
      if ($urandom_range(1, 0) == 1) vv = 32'hFFFFFFFF;
      run_walk(20'($urandom()), 22'($urandom()), rand_pte($urandom_range(2, 0)),
               rand_pte($urandom_range(2, 1)), vv, $urandom_range(3, 0));
    end

    // Reset while waiting for the level-0 PTE, then a stray response.
    @(negedge clk);
    bus_if.walk_vpn      = 20'h12345;
    bus_if.satp_ppn      = 22'h00100;
    bus_if.tlb_valid_vec = 32'h0;
    bus_if.walk_start    = 1'b1;
    @(negedge clk);
    bus_if.walk_start = 1'b0;
    check_eq("rst_seq_l1_req", bus_if.mem_req, 1'b1);
    bus_if.mem_ready = 1'b1;
    @(negedge clk);
    bus_if.mem_ready  = 1'b0;
    bus_if.mem_rvalid = 1'b1;
    bus_if.mem_rdata  = 32'h00080001;
    @(negedge clk);
    bus_if.mem_rvalid = 1'b0;
    check_eq("rst_seq_l0_req", bus_if.mem_req, 1'b1);
    check_eq("rst_seq_l0_addr", bus_if.mem_addr, 34'h000200D14);
    bus_if.mem_ready = 1'b1;
    @(negedge clk);
    bus_if.mem_ready = 1'b0;
    check_eq("rst_seq_wait_busy", bus_if.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_busy", bus_if.busy, 1'b0);
    check_eq("midrst_mem_req", bus_if.mem_req, 1'b0);
    check_eq("midrst_mem_addr", bus_if.mem_addr, 34'h0);
    check_eq("midrst_we", bus_if.tlb_we, 1'b0);
    check_eq("midrst_pulses", {bus_if.walk_done, bus_if.walk_fault}, 2'b00);
    model_rp = 0;
    bus_if.mem_rvalid = 1'b1;
    bus_if.mem_rdata  = 32'h02AF34CB;
    @(negedge clk);
    bus_if.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("stray_we", bus_if.tlb_we, 1'b0);
      check_eq("stray_busy", bus_if.busy, 1'b0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end
endmodule
